uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the team's UART transmitter, using the same frame format: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, line idle high.
- Oversamples the asynchronous serial input at the system clock.
- Validates start and stop bits.
- Presents each received word on a valid/ack holding register to the core logic.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); minimum 4
DATA_BITS, 8, data bits per frame; range 5..8

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line, asynchronous to clk
rx_ack  input  1  consumer acknowledges rx_data; clears rx_valid
rx_data  output  DATA_BITS  last correctly framed word
rx_valid  output  1  rx_data holds an unacknowledged word
busy  output  1  frame reception in progress (state != IDLE)
frame_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: new word written while rx_valid=1
parity_error  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Clock, reset: clock clk; reset reset, asynchronous, active-low.
- Reset values:
  - Two-flop synchronizer flops = 1.
  - State = IDLE.
  - rx_data = 0.
  - rx_valid, busy, frame_error, overrun, parity_error = 0.
  - Bit counter and timer = 0.
- Synchronized line rxs = second synchronizer flop: 2-cycle latency. All decisions use rxs only.
- Timer counts 0..CLKS_PER_BIT-1; bit counter counts 0..DATA_BITS-1.
- FSM states (enum RX_STATE): IDLE, START, DATA, STOP, HOLD.
  - IDLE: rxs=0 -> START, timer cleared.
  - START: at timer = CLKS_PER_BIT/2-1 (integer division):
    - rxs=0 -> DATA; timer cleared, bit counter cleared.
    - rxs=1 -> IDLE (glitch rejected, no flag).
  - DATA: at timer = CLKS_PER_BIT-1:
    - Shift rxs into the MSB of the shift register (shift right, so the first bit lands in bit 0 after DATA_BITS shifts).
    - Timer cleared.
    - Bit counter = DATA_BITS-1 at this sample -> STOP; otherwise increment the bit counter.
  - STOP: at timer = CLKS_PER_BIT-1:
    - rxs=1 -> IDLE; word accepted.
    - rxs=0 -> HOLD; frame_error pulses; word discarded.
  - HOLD: wait for rxs=1, then -> IDLE. Prevents a break condition from retriggering reception.
- Word accept, registered on the cycle after the stop sample:
  - rx_data <= shift register; rx_valid <= 1.
  - If rx_valid was 1 and rx_ack is not asserted that cycle: overrun pulses and rx_data is overwritten.
  - Simultaneous rx_ack and accept: rx_valid stays 1, new data, no overrun.
- rx_ack while rx_valid=1 -> rx_valid=0 next cycle. rx_ack while rx_valid=0 is ignored.
- On frame_error, rx_data and rx_valid are unchanged.
- Sampling is mid-bit. The frame returns to IDLE mid-stop-bit, so back-to-back frames are accepted with zero idle time.
- Reset asserted mid-frame: immediate return to reset values. The partial word is lost with no flag. After release, a line still low mid-frame is treated as a new start edge.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at CLKS_PER_BIT-1.
  - Even parity is checked against the XOR of the data bits.
  - On mismatch, parity_error pulses in the cycle after the stop sample. The word is still delivered, and rx_valid is set if framing is correct.
- Undefined: no PARITY state; parity_error tied to 0.

Decomposition:
- RX_STATE enum belongs in the shared DataTypes package alongside the transmitter state type.
- Package constant DEFAULT_CLKS_PER_BIT = 434.
- One sub-module: uart_rx_sync, the two-flop synchronizer with reset value 1. It is reusable for other asynchronous inputs.
- FSM, timer, shift register and output register stay in uart_rx.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and DATA_BITS=8.
- Send 0xA5 with a valid stop bit -> rx_data=0xA5 and rx_valid=1, exactly 2+8+16*9+1 cycles after the falling edge; the next cycle's rx_ack clears rx_valid.
- Low pulse of 5 cycles on an idle line -> returns to IDLE; rx_valid, frame_error and busy low after the return.
- Send 0x3C with the stop bit driven 0, then hold the line low for 40 cycles -> frame_error pulses once, FSM stays in HOLD, no second frame_error, rx_valid unchanged.
- Send 0x11 then 0x22 back-to-back without rx_ack -> overrun pulses once, rx_data=0x22. Repeat with rx_ack asserted on the second accept cycle -> no overrun.
- Assert reset at bit 4 of 0xFF -> all outputs 0 immediately. A subsequent 0x5A frame is received correctly.
- With UART_RX_PARITY_EN defined: 0x07 followed by parity bit 0 -> parity_error pulses and rx_data=0x07. The same frame with parity bit 1 -> no parity_error.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART data types: transmitter and receiver state encodings plus default timing.
// UART_RX_PARITY_EN adds the receiver PARITY state.
package uart_rx_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
`ifdef UART_RX_PARITY_EN
    HOLD,
    PARITY
`else
    HOLD
`endif
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both flops reset to 1.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop; mid-bit sampling, valid/ack output.
// Define UART_RX_PARITY_EN to receive and check an even parity bit before the stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 parity_error
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rxs;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  // Receive FSM; outputs update on the edge that takes the stop sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      busy         <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (rx_ack && rx_valid) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == T_LAST) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            timer <= '0;
            if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == T_LAST) begin
            parity_bad <= (rxs != ^shreg);
            timer      <= '0;
            state      <= STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif
        STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
`ifdef UART_RX_PARITY_EN
            parity_error <= parity_bad;
`endif
            if (rxs) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack) overrun <= 1'b1;
            end else begin
              state       <= HOLD;
              frame_error <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        // Break condition: wait for the line to return high before re-arming.
        HOLD: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule
